// File: rtl/craft_cipher_core.sv
// Iterative CRAFT tweakable block cipher core, ROUNDS_PER_CYCLE rounds unrolled per clock.
// Define CRAFT_DECRYPT_EN to compile in the decrypt datapath (mode = 1 decrypts).
module craft_cipher_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [63:0]  text_in,
    input  logic [63:0]  tweak,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  text_out,
    output logic         busy
);
    localparam int R = ROUNDS_PER_CYCLE;

    if (R != 1 && R != 2 && R != 4 && R != 8 && R != 16 && R != 32) begin : g_bad_rpc
        $error("craft_cipher_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end

    localparam logic [3:0] SBOX [16] = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                                        4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
    localparam int PERM  [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
    localparam int QPERM [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
    // {RC4, 0, RC3} per round, XORed onto nibbles 4 and 5
    localparam logic [7:0] RC [32] = '{
        8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hC7, 8'h63, 8'hB1,
        8'h54, 8'hA2, 8'hD5, 8'hE6, 8'hF7, 8'h73, 8'h31, 8'h14,
        8'h82, 8'h45, 8'h26, 8'h97, 8'hC3, 8'h61, 8'hB4, 8'h52,
        8'hA5, 8'hD6, 8'hE7, 8'hF3, 8'h71, 8'h34, 8'h12, 8'h85};

    function automatic logic [63:0] sbox_all(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[63-4*i -: 4] = SBOX[s[63-4*i -: 4]];
        return r;
    endfunction

    function automatic logic [63:0] perm_fwd(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[63-4*PERM[i] -: 4] = s[63-4*i -: 4];
        return r;
    endfunction

    function automatic logic [63:0] q_perm(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[63-4*i -: 4] = s[63-4*QPERM[i] -: 4];
        return r;
    endfunction

    // Row 0 ^= rows 2,3; row 1 ^= row 3 (an involution)
    function automatic logic [63:0] mix_col(input logic [63:0] s);
        return {s[63:48] ^ s[31:16] ^ s[15:0], s[47:32] ^ s[15:0], s[31:0]};
    endfunction

    function automatic logic [63:0] enc_round(input logic [63:0] s, input logic [4:0] idx,
                                              input logic [63:0] tk_i);
        logic [63:0] r;
        r = mix_col(s);
        r[47:40] = r[47:40] ^ RC[idx];
        r = r ^ tk_i;
        if (idx != 5'd31) r = sbox_all(perm_fwd(r));
        return r;
    endfunction

`ifdef CRAFT_DECRYPT_EN
    function automatic logic [63:0] perm_inv(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[63-4*i -: 4] = s[63-4*PERM[i] -: 4];
        return r;
    endfunction

    function automatic logic [63:0] dec_round(input logic [63:0] s, input logic [4:0] idx,
                                              input logic [63:0] tk_i);
        logic [63:0] r;
        r = s;
        if (idx != 5'd31) r = perm_inv(sbox_all(r));
        r = r ^ tk_i;
        r[47:40] = r[47:40] ^ RC[idx];
        return mix_col(r);
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic             armed;
    logic [63:0]      data;
    logic [3:0][63:0] tk;
    logic [4:0]       ctr, ctr_next;
    logic             last_step;
    logic [63:0]      stage [R+1];

`ifdef CRAFT_DECRYPT_EN
    logic dec;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    assign stage[0] = data;

    for (genvar k = 0; k < R; k++) begin : g_round
        logic [4:0] idx;
`ifdef CRAFT_DECRYPT_EN
        assign idx          = dec ? ctr - 5'(k) : ctr + 5'(k);
        assign stage[k + 1] = dec ? dec_round(stage[k], idx, tk[idx[1:0]])
                                  : enc_round(stage[k], idx, tk[idx[1:0]]);
`else
        assign idx          = ctr + 5'(k);
        assign stage[k + 1] = enc_round(stage[k], idx, tk[idx[1:0]]);
`endif
    end

    always_comb begin
`ifdef CRAFT_DECRYPT_EN
        last_step = dec ? (ctr == 5'(R - 1)) : (ctr == 5'(32 - R));
        ctr_next  = dec ? ctr - 5'(R) : ctr + 5'(R);
`else
        last_step = (ctr == 5'(32 - R));
        ctr_next  = ctr + 5'(R);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid && armed) state_nxt = RUN;
            RUN:     if (last_step)         state_nxt = DONE;
            DONE:    if (out_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = armed && (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed    <= 1'b0;
            data     <= '0;
            tk       <= '0;
            ctr      <= '0;
            text_out <= '0;
`ifdef CRAFT_DECRYPT_EN
            dec      <= 1'b0;
`endif
        end else begin
            armed <= 1'b1;
            if (in_valid && in_ready) begin
                data  <= text_in;
                tk[0] <= key[127:64] ^ tweak;
                tk[1] <= key[63:0] ^ tweak;
                tk[2] <= key[127:64] ^ q_perm(tweak);
                tk[3] <= key[63:0] ^ q_perm(tweak);
`ifdef CRAFT_DECRYPT_EN
                dec   <= mode;
                ctr   <= mode ? 5'd31 : 5'd0;
`else
                ctr   <= 5'd0;
`endif
            end else if (state == RUN) begin
                data <= stage[R];
                if (last_step) text_out <= stage[R];
                else           ctr      <= ctr_next;
            end
        end
    end
endmodule

// File: tb/tb_craft_cipher_core.sv
// Self-checking bench for craft_cipher_core: array-based CRAFT model, in-order scoreboard,
// parameter sweep instances, back-pressure, mid-run reset and random streaming.
module tb_craft_cipher_core;
    localparam int MAIN_LAT = 32;
    localparam logic [63:0]  KAT_PT  = 64'h5734F006D8D88A3E;
    localparam logic [63:0]  KAT_TW  = 64'h54CD94FFD0670A58;
    localparam logic [127:0] KAT_KEY = 128'h27A6781A43F364BC916708D5FBB5AEFE;

    localparam logic [3:0] M_SB [16] = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                                        4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
    localparam int M_P [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
    localparam int M_Q [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic [63:0]  text_in, tweak, text_out;
    logic [127:0] key;
    logic         sw_en;
    logic         sw_in_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_res    = 0;
    logic [63:0] kat_ct;
    logic [63:0] exp_q [$];
    int          acc_q [$];
    logic        prev_ov = 1'b0;
    logic [63:0] prev_txt = '0;
    bit          stream_stop;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sw_in_valid = in_valid && sw_en;

    craft_cipher_core #(.ROUNDS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .text_in(text_in), .tweak(tweak), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .text_out(text_out), .busy(busy));

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Round constants from the two LFSRs (4-bit and 3-bit), stepped i times from 1
    function automatic logic [7:0] rc_byte(input int i);
        logic [3:0] a;
        logic [2:0] b;
        a = 4'h1;
        b = 3'h1;
        for (int j = 0; j < i; j++) begin
            a = {a[0] ^ a[1], a[3:1]};
            b = {b[0] ^ b[1], b[2:1]};
        end
        return {a, 1'b0, b};
    endfunction

    function automatic logic [63:0] q_model(input logic [63:0] t);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[63-4*i -: 4] = t[63-4*M_Q[i] -: 4];
        return r;
    endfunction

    function automatic logic [63:0] craft_model(input logic dec, input logic [63:0] txt,
                                                input logic [63:0] tw, input logic [127:0] k);
        logic [3:0]  s [16];
        logic [3:0]  t [16];
        logic [3:0]  tkn [4][16];
        logic [63:0] qt;
        logic [63:0] r;
        logic [7:0]  rc;
        int          rnd;
        qt = q_model(tw);
        for (int i = 0; i < 16; i++) begin
            s[i]      = txt[63-4*i -: 4];
            tkn[0][i] = k[127-4*i -: 4] ^ tw[63-4*i -: 4];
            tkn[1][i] = k[63-4*i -: 4]  ^ tw[63-4*i -: 4];
            tkn[2][i] = k[127-4*i -: 4] ^ qt[63-4*i -: 4];
            tkn[3][i] = k[63-4*i -: 4]  ^ qt[63-4*i -: 4];
        end
        for (int n = 0; n < 32; n++) begin
            rnd = dec ? 31 - n : n;
            rc  = rc_byte(rnd);
            if (!dec) begin
                for (int c = 0; c < 4; c++) begin
                    s[c]     = s[c] ^ s[c+8] ^ s[c+12];
                    s[c + 4] = s[c+4] ^ s[c+12];
                end
                s[4] = s[4] ^ rc[7:4];
                s[5] = s[5] ^ rc[3:0];
                for (int i = 0; i < 16; i++) s[i] = s[i] ^ tkn[rnd % 4][i];
                if (rnd != 31) begin
                    for (int i = 0; i < 16; i++) t[M_P[i]] = s[i];
                    for (int i = 0; i < 16; i++) s[i] = M_SB[t[i]];
                end
            end else begin
                if (rnd != 31) begin
                    for (int i = 0; i < 16; i++) t[i] = M_SB[s[i]];
                    for (int i = 0; i < 16; i++) s[i] = t[M_P[i]];
                end
                for (int i = 0; i < 16; i++) s[i] = s[i] ^ tkn[rnd % 4][i];
                s[4] = s[4] ^ rc[7:4];
                s[5] = s[5] ^ rc[3:0];
                for (int c = 0; c < 4; c++) begin
                    s[c]     = s[c] ^ s[c+8] ^ s[c+12];
                    s[c + 4] = s[c+4] ^ s[c+12];
                end
            end
        end
        for (int i = 0; i < 16; i++) r[63-4*i -: 4] = s[i];
        return r;
    endfunction

    // Scoreboard: inputs change at posedge+1, so at negedge everything is settled
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (busy) check64("in_ready_in_run", {63'd0, in_ready}, 64'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check64("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    if (!prev_ov) check64("latency", 64'(cyc - acc_q[0]), 64'(MAIN_LAT));
                    else          check64("hold_stable", text_out, prev_txt);
                    check64("text_out", text_out, exp_q[0]);
                    check64("in_ready_in_done", {63'd0, in_ready}, 64'd0);
                    check64("busy_in_done", {63'd0, busy}, 64'd0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        n_res++;
                    end
                end
            end
            if (in_valid && in_ready) begin
`ifdef CRAFT_DECRYPT_EN
                exp_q.push_back(craft_model(mode, text_in, tweak, key));
`else
                exp_q.push_back(craft_model(1'b0, text_in, tweak, key));
`endif
                acc_q.push_back(cyc + 1);
            end
            prev_ov  = out_valid && !out_ready;
            prev_txt = text_out;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int RPC = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
        logic        ir, ov, bz;
        logic [63:0] to;
        int          results = 0;
        int          acc_cyc = 0;
        craft_cipher_core #(.ROUNDS_PER_CYCLE(RPC)) u_dut (
            .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(ir), .mode(1'b0),
            .text_in(text_in), .tweak(tweak), .key(key), .out_valid(ov),
            .out_ready(1'b1), .text_out(to), .busy(bz));
        always @(negedge clk) begin
            if (!rst) begin
                if (ov) begin
                    check64($sformatf("sweep_rpc%0d_latency", RPC), 64'(cyc - acc_cyc), 64'(32 / RPC));
                    check64($sformatf("sweep_rpc%0d_text", RPC), to, kat_ct);
                    check64($sformatf("sweep_rpc%0d_busy", RPC), {63'd0, bz}, 64'd0);
                    results++;
                end
                if (sw_in_valid && ir) acc_cyc = cyc + 1;
            end
        end
    end

    // Call at posedge+1; holds in_valid until the core takes the request
    task automatic send(input logic [63:0] t, input logic [63:0] tw, input logic [127:0] k,
                        input logic m);
        bit acc;
        acc = 1'b0;
        text_in  = t;
        tweak    = tw;
        key      = k;
        mode     = m;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check64("send_accepted", {63'd0, acc}, 64'd1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (exp_q.size() == 0) && !out_valid;
        end
        check64("drain_done", {63'd0, ok}, 64'd1);
    endtask

    task automatic junk();
        in_valid = 1'($urandom);
        mode     = 1'($urandom);
        text_in  = {$urandom, $urandom};
        tweak    = {$urandom, $urandom};
        key      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int base;
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; text_in = '0; tweak = '0; key = '0;
        out_ready = 1'b1; sw_en = 1'b0; stream_stop = 1'b0;

        // Pin the model's building blocks against hand-derived values
        check64("rc_round0", {56'd0, rc_byte(0)}, 64'h11);
        check64("rc_round16", {56'd0, rc_byte(16)}, 64'h82);
        check64("rc_round31", {56'd0, rc_byte(31)}, 64'h85);
        check64("q_perm", q_model(64'h0123456789ABCDEF), 64'hCAF5E892B374601D);
        kat_ct = craft_model(1'b0, KAT_PT, KAT_TW, KAT_KEY);
        check64("model_roundtrip", craft_model(1'b1, kat_ct, KAT_TW, KAT_KEY), KAT_PT);

        repeat (3) @(posedge clk);
        #1;
        check64("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check64("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check64("rst_busy", {63'd0, busy}, 64'd0);
        check64("rst_text_out", text_out, 64'd0);
        rst = 1'b0;
        #1;
        check64("in_ready_before_first_clk", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check64("in_ready_after_first_clk", {63'd0, in_ready}, 64'd1);

        // Known answer at 1 round/clock, sweep instances run the same request
        sw_en = 1'b1;
        send(KAT_PT, KAT_TW, KAT_KEY, 1'b0);
        sw_en = 1'b0;
        drain();
        check64("sweep_rpc2_count", 64'(g_sweep[0].results), 64'd1);
        check64("sweep_rpc4_count", 64'(g_sweep[1].results), 64'd1);
        check64("sweep_rpc8_count", 64'(g_sweep[2].results), 64'd1);
        check64("sweep_rpc32_count", 64'(g_sweep[3].results), 64'd1);

        // Round trip (plain encryption of the ciphertext when decrypt is not built)
        send(kat_ct, KAT_TW, KAT_KEY, 1'b1);
`ifdef CRAFT_DECRYPT_EN
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                check64("roundtrip_plaintext", text_out, 64'h5734F006D8D88A3E);
            end
        end
        check64("roundtrip_seen", {63'd0, seen}, 64'd1);
`endif
        drain();

        // Back-pressure with garbage on every input
        out_ready = 1'b0;
        send(KAT_PT, KAT_TW, KAT_KEY, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            junk();
            @(posedge clk);
            #1;
            seen = out_valid;
        end
        check64("bp_out_valid_seen", {63'd0, seen}, 64'd1);
        repeat (20) begin
            junk();
            @(posedge clk);
            #1;
        end
        check64("bp_result", text_out, kat_ct);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset ten cycles into RUN
        send(KAT_PT, KAT_TW, KAT_KEY, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check64("busy_before_reset", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check64("midrst_busy", {63'd0, busy}, 64'd0);
        check64("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check64("midrst_text_out", text_out, 64'd0);
        check64("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(KAT_PT, KAT_TW, KAT_KEY, 1'b0);
        drain();

        // Random streaming with gaps on both sides
        base = n_res;
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    send({$urandom, $urandom}, {$urandom, $urandom},
                         {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
                end
                drain();
                stream_stop = 1'b1;
            end
            begin
                while (!stream_stop) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        check64("stream_result_count", 64'(n_res - base), 64'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/craft_cipher_core.md
# craft_cipher_core

Iterative CRAFT tweakable block cipher core (64-bit block, 64-bit tweak, 128-bit key, 32 rounds) with a configurable number of rounds unrolled per clock, valid/ready handshakes on both sides and optional decryption. It succeeds the fixed single-mode encrypt core and sits between the tweak/key front end and the output buffer of the crypto datapath. One block is processed at a time. The input register, key and tweak are captured on acceptance, so callers may change them during a block.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds evaluated per clock. Legal values are 1, 2, 4, 8, 16 and 32. Any other value triggers an elaboration `$error`.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset. Asynchronous, active-high.
- `in_valid` input, 1 bit: request valid.
- `in_ready` output, 1 bit: core can accept a request.
- `mode` input, 1 bit: 0 selects encrypt, 1 selects decrypt. Sampled with the request.
- `text_in` input, 64 bits: plaintext or ciphertext, nibble 0 at [63:60].
- `tweak` input, 64 bits: tweak T.
- `key` input, 128 bits: K0 = [127:64], K1 = [63:0].
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `text_out` output, 64 bits: result.
- `busy` output, 1 bit: high in RUN.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - When `in_valid` is high, capture `text_in`, `mode`, TK0..TK3 and the round counter (0 for encrypt, 31 for decrypt), then go to RUN.
- **Tweakeys:**
  - TK0 = K0^T, TK1 = K1^T, TK2 = K0^Q(T), TK3 = K1^Q(T).
  - Q is the nibble permutation [12,10,15,5,14,8,9,2,11,3,7,4,6,0,1,13].
  - Round i uses TK[i mod 4].
- **Encrypt round i:** MixColumn, then AddConstant (RC3/RC4 of round i, taken from the codebase round-constant generator), then AddTweakey, then PermuteNibbles, then S-box.
  - Round 31 omits PermuteNibbles and S-box.
- **Decrypt:** rounds run i = 31 down to 0, each the exact inverse of the encrypt round.
  - The S-box and MixColumn are involutions.
  - PermuteNibbles uses the inverse permutation.
  - Constants and tweakeys are indexed by i.
- **RUN:**
  - Each clock applies `ROUNDS_PER_CYCLE` consecutive rounds combinationally.
  - The counter steps by ±`ROUNDS_PER_CYCLE`.
  - After the step containing the final round (31 for encrypt, 0 for decrypt), latch the result into `text_out` and go to DONE.
- **DONE:**
  - `out_valid` = 1 and `text_out` is held stable until `out_ready` is high.
  - On that handshake go to IDLE.
  - Back-pressure is unlimited, and no new request is accepted while in DONE.
- **Counter:** 5-bit, with no wrap-around. It is never stepped past the final round index.
- **Reset:**
  - Asserting `rst` at any time, including mid-RUN, forces IDLE immediately.
  - Reset values: `in_ready` = 0 while `rst` is asserted and 1 from the first clock after release; `out_valid` = 0; `busy` = 0; `text_out` = 0; counter = 0.
  - Any in-flight block is discarded.

## Timing
- **Acceptance:** a request is accepted on the edge where `in_valid && in_ready`.
- **Latency:** `out_valid` rises 32/`ROUNDS_PER_CYCLE` clocks after the accepting edge.
  - `ROUNDS_PER_CYCLE` = 1 gives 32 cycles; 4 gives 8 cycles; 32 gives 1 cycle.
- **Back-to-back throughput:** one block per 32/`ROUNDS_PER_CYCLE` + 2 cycles when `out_ready` is tied high. The extra 2 cycles are DONE → IDLE and the IDLE acceptance.
- **`in_ready` combinational paths:** `in_ready` does not depend combinationally on `in_valid` or `out_ready`.
- **`mode` / `text_in` / `tweak` / `key` timing:** these are don't-care outside the accepting edge.

## Configuration
- **`CRAFT_DECRYPT_EN` defined:**
  - The decrypt path, the inverse permutation and the descending counter are compiled in.
  - `mode` = 1 performs decryption.
- **`CRAFT_DECRYPT_EN` undefined:**
  - Only the encrypt datapath exists.
  - `mode` is ignored and every request is encrypted, with identical latency.
  - The decrypt path costs no area.

## Test plan
1. **Encrypt known answer.** `ROUNDS_PER_CYCLE` = 1.
   - Stimulus: `text_in` = 64'h5734F006D8D88A3E, `tweak` = 64'h54CD94FFD0670A58, `key` = 128'h27A6781A43F364BC916708D5FBB5AEFE, `mode` = 0.
   - Required: `text_out` equals the team's CRAFT software model output, and `out_valid` rises exactly 32 cycles after acceptance.
2. **Round-trip.** `CRAFT_DECRYPT_EN` defined.
   - Stimulus: feed the ciphertext from scenario 1 back with `mode` = 1 and the same key and tweak.
   - Required: `text_out` = 64'h5734F006D8D88A3E.
3. **Parameter sweep.** Run scenario 1 for `ROUNDS_PER_CYCLE` ∈ {2, 4, 8, 32}.
   - Required: identical ciphertext, with latencies 16, 8, 4 and 1 respectively.
4. **Back-pressure.**
   - Stimulus: hold `out_ready` = 0 for 20 cycles after `out_valid` rises; toggle `in_valid`, `text_in`, `key` and `tweak` throughout.
   - Required: `text_out` stable, `in_ready` = 0, and the result still matches scenario 1.
5. **Mid-operation reset.**
   - Stimulus: assert `rst` for 1 cycle 10 cycles into RUN.
   - Required: `busy` = 0, `out_valid` = 0 and `text_out` = 0 immediately; a fresh request afterwards produces the correct scenario 1 result.
6. **Streaming.**
   - Stimulus: 100 random (text, tweak, key, mode) requests with random `in_valid` and `out_ready` gaps.
   - Required: every result matches the model, in order, with none dropped or duplicated.
